// File: rtl/flitzip_pkg.sv
// +----------------------------------------------------------------------------+
// | flitzip_pkg                                                                |
// | Default widths, raw encoding code and signed-width helper for flitzip.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package flitzip_pkg;

  localparam int DEF_INPUT_WIDTH  = 128;
  localparam int DEF_CHUNK_SIZE   = 8;
  localparam int DEF_EN_BITS      = 4;
  localparam int DEF_OUTPUT_WIDTH = 128;
  localparam int RAW_CODE         = DEF_CHUNK_SIZE;

  // Smallest two's-complement width holding v; 0 only for v == 0.
  function automatic int signed_width(input logic signed [31:0] v);
    logic signed [31:0] lo;
    logic signed [31:0] hi;
    int                 w;
    w = 32;
    for (int i = 31; i >= 1; i--) begin
      lo = -(32'sd1 <<< (i - 1));
      hi = (32'sd1 <<< (i - 1)) - 32'sd1;
      if (v >= lo && v <= hi) w = i;
    end
    if (v == 32'sd0) w = 0;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bd_delta_pack.sv
// +----------------------------------------------------------------------------+
// | bd_delta_pack                                                              |
// | Base/delta computation, delta width selection and field packing.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bd_delta_pack
  import flitzip_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int CHUNK_SIZE   = DEF_CHUNK_SIZE,
  parameter int NUM_CHUNKS   = INPUT_WIDTH / CHUNK_SIZE,
  parameter int EN_BITS      = DEF_EN_BITS,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
  input  logic [INPUT_WIDTH-1:0]  data_in,
  input  logic                    is_head,
  input  logic [CHUNK_SIZE-1:0]   cmin,
  input  logic [CHUNK_SIZE-1:0]   cmax,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic [EN_BITS-1:0]      en_out,
  output logic [15:0]             len_out
);

  logic [CHUNK_SIZE:0]     w_sum;
  logic [CHUNK_SIZE-1:0]   w_base;
  logic [CHUNK_SIZE:0]     w_delta [NUM_CHUNKS];
  logic [OUTPUT_WIDTH-1:0] w_mask;
  logic [OUTPUT_WIDTH-1:0] w_packed;
  logic                    w_raw;
  int                      w_width;
  int                      w_cw;

  always_comb begin
    w_sum    = {1'b0, cmax} + {1'b0, cmin};
    w_base   = w_sum[CHUNK_SIZE:1];
    w_width  = 0;
    w_cw     = 0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      // Deltas are CHUNK_SIZE+1-bit two's complement; sign-extend for sizing.
      w_delta[i] = {1'b0, data_in[i*CHUNK_SIZE +: CHUNK_SIZE]} - {1'b0, w_base};
      w_cw       = signed_width({{(31-CHUNK_SIZE){w_delta[i][CHUNK_SIZE]}}, w_delta[i]});
      if (w_cw > w_width) w_width = w_cw;
    end

    w_raw    = is_head || (w_width >= CHUNK_SIZE);
    w_mask   = (OUTPUT_WIDTH'(1) << w_width) - OUTPUT_WIDTH'(1);
    w_packed = OUTPUT_WIDTH'(w_base);
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      w_packed = w_packed |
                 ((OUTPUT_WIDTH'(w_delta[i]) & w_mask) << (CHUNK_SIZE + i * w_width));
    end

    if (w_raw) begin
      data_out = OUTPUT_WIDTH'(data_in);
      en_out   = EN_BITS'(CHUNK_SIZE);
      len_out  = 16'(INPUT_WIDTH);
    end else begin
      data_out = w_packed;
      en_out   = EN_BITS'(w_width);
      len_out  = 16'(CHUNK_SIZE + NUM_CHUNKS * w_width);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bd_flit_compressor.sv
// +----------------------------------------------------------------------------+
// | bd_flit_compressor                                                         |
// | Two-stage base-delta flit compressor with valid/ready flow control.        |
// | Optional statistics counters: define FLITZIP_STATS_EN.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bd_flit_compressor
  import flitzip_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int CHUNK_SIZE   = DEF_CHUNK_SIZE,
  parameter int NUM_CHUNKS   = INPUT_WIDTH / CHUNK_SIZE,
  parameter int EN_BITS      = DEF_EN_BITS,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    is_head,
  input  logic [INPUT_WIDTH-1:0]  data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic [EN_BITS-1:0]      en_out,
  output logic [15:0]             len_out,
  output logic                    is_head_out
`ifdef FLITZIP_STATS_EN
  ,
  output logic [31:0]             stat_comp_cnt,
  output logic [31:0]             stat_raw_cnt
`endif
);

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_head_q,  s1_head_d;
  logic [INPUT_WIDTH-1:0]  s1_data_q,  s1_data_d;
  logic [CHUNK_SIZE-1:0]   s1_cmin_q,  s1_cmin_d;
  logic [CHUNK_SIZE-1:0]   s1_cmax_q,  s1_cmax_d;

  logic                    s2_valid_q, s2_valid_d;
  logic                    s2_head_q,  s2_head_d;
  logic [OUTPUT_WIDTH-1:0] s2_data_q,  s2_data_d;
  logic [EN_BITS-1:0]      s2_en_q,    s2_en_d;
  logic [15:0]             s2_len_q,   s2_len_d;

  logic                    w_s1_ready, w_s2_ready, w_s1_load, w_s2_load;
  logic [CHUNK_SIZE-1:0]   w_cmin, w_cmax;
  logic [OUTPUT_WIDTH-1:0] w_pk_data;
  logic [EN_BITS-1:0]      w_pk_en;
  logic [15:0]             w_pk_len;

  always_comb begin
    w_cmin = data_in[CHUNK_SIZE-1:0];
    w_cmax = data_in[CHUNK_SIZE-1:0];
    for (int i = 1; i < NUM_CHUNKS; i++) begin
      if (data_in[i*CHUNK_SIZE +: CHUNK_SIZE] < w_cmin) w_cmin = data_in[i*CHUNK_SIZE +: CHUNK_SIZE];
      if (data_in[i*CHUNK_SIZE +: CHUNK_SIZE] > w_cmax) w_cmax = data_in[i*CHUNK_SIZE +: CHUNK_SIZE];
    end
  end

  bd_delta_pack #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .CHUNK_SIZE   (CHUNK_SIZE),
    .NUM_CHUNKS   (NUM_CHUNKS),
    .EN_BITS      (EN_BITS),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_pack (
    .data_in  (s1_data_q),
    .is_head  (s1_head_q),
    .cmin     (s1_cmin_q),
    .cmax     (s1_cmax_q),
    .data_out (w_pk_data),
    .en_out   (w_pk_en),
    .len_out  (w_pk_len)
  );

  // Each stage accepts when empty or when its current occupant leaves this edge.
  always_comb begin
    w_s2_ready = !s2_valid_q || out_ready;
    w_s1_ready = !s1_valid_q || w_s2_ready;
    in_ready   = w_s1_ready && !rst_in;
    w_s1_load  = in_valid && in_ready;
    w_s2_load  = s1_valid_q && w_s2_ready;

    s1_valid_d = w_s1_load ? 1'b1 : (w_s2_ready ? 1'b0 : s1_valid_q);
    s1_head_d  = w_s1_load ? is_head : s1_head_q;
    s1_data_d  = w_s1_load ? data_in : s1_data_q;
    s1_cmin_d  = w_s1_load ? w_cmin  : s1_cmin_q;
    s1_cmax_d  = w_s1_load ? w_cmax  : s1_cmax_q;

    s2_valid_d = w_s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
    s2_head_d  = w_s2_load ? s1_head_q : s2_head_q;
    s2_data_d  = w_s2_load ? w_pk_data : s2_data_q;
    s2_en_d    = w_s2_load ? w_pk_en   : s2_en_q;
    s2_len_d   = w_s2_load ? w_pk_len  : s2_len_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_head_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_cmin_q  <= '0;
      s1_cmax_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_head_q  <= 1'b0;
      s2_data_q  <= '0;
      s2_en_q    <= '0;
      s2_len_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_head_q  <= s1_head_d;
      s1_data_q  <= s1_data_d;
      s1_cmin_q  <= s1_cmin_d;
      s1_cmax_q  <= s1_cmax_d;
      s2_valid_q <= s2_valid_d;
      s2_head_q  <= s2_head_d;
      s2_data_q  <= s2_data_d;
      s2_en_q    <= s2_en_d;
      s2_len_q   <= s2_len_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign data_out    = s2_data_q;
  assign en_out      = s2_en_q;
  assign len_out     = s2_len_q;
  assign is_head_out = s2_head_q;

`ifdef FLITZIP_STATS_EN
  logic [31:0] comp_cnt_q, comp_cnt_d;
  logic [31:0] raw_cnt_q,  raw_cnt_d;

  always_comb begin
    comp_cnt_d = comp_cnt_q;
    raw_cnt_d  = raw_cnt_q;
    if (s2_valid_q && out_ready) begin
      if (s2_en_q < EN_BITS'(CHUNK_SIZE)) begin
        if (comp_cnt_q != '1) comp_cnt_d = comp_cnt_q + 32'd1;
      end else begin
        if (raw_cnt_q != '1) raw_cnt_d = raw_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      comp_cnt_q <= '0;
      raw_cnt_q  <= '0;
    end else begin
      comp_cnt_q <= comp_cnt_d;
      raw_cnt_q  <= raw_cnt_d;
    end
  end

  assign stat_comp_cnt = comp_cnt_q;
  assign stat_raw_cnt  = raw_cnt_q;
`endif

endmodule

`default_nettype wire
